pcie_h2c_pkt_validator: RTL and testbench

Store-and-forward validator between the PCIe DMA H2C AXI-Stream output and the KVS RX stream input, in the user_clk_250 domain. It buffers each host packet, checks the 64-bit header and the framing against the declared length, and forwards only well-formed packets. Malformed packets are dropped whole, so the KVS never sees a partial or corrupt request. Statistics counters expose good and dropped packets to the host.

---
 rtl/pcie_h2c_pkt_validator.sv | 242 ++++++++++++++++++++++++
 tb/tb_pcie_h2c_pkt_validator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_h2c_pkt_validator.sv
// pcie_h2c_pkt_validator
//
// Store-and-forward packet validator between the PCIe DMA H2C AXI-Stream and
// the KVS RX stream. Every incoming packet is written into a circular beat
// buffer. It becomes visible to the egress side only after the whole packet
// has passed the header and framing checks (commit). A packet that fails is
// removed by rewinding the write pointer to the last commit point, so egress
// never sees a partial or corrupt request.
//
// State table:
//   HDR  | waiting for beat 0; checks magic/length, latches the expected size
//   BODY | mid-packet; checks tkeep and tlast position on every beat
//   DROP | packet already rejected; swallows beats up to and including tlast
//
// Ports:
//   clk, sys_rst         user_clk_250, synchronous active-high reset
//   s_axis_*             H2C input stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_*             KVS RX output stream
//   stat_good_pkts       committed packets, saturating
//   stat_drop_pkts       dropped packets, saturating
//   stat_last_err        code of the most recent drop
//                        (1 magic, 2 length, 3 early tlast, 4 missing tlast,
//                         5 tkeep)
//   err_pulse            one-cycle pulse per dropped packet
module pcie_h2c_pkt_validator #(
    parameter int          DATA_WIDTH    = 256,
    parameter int          FIFO_DEPTH    = 64,
    parameter int          MAX_PKT_BEATS = 32,
    parameter logic [15:0] MAGIC         = 16'hC0DE
) (
    input  logic                      clk,
    input  logic                      sys_rst,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [31:0]               stat_good_pkts,
    output logic [31:0]               stat_drop_pkts,
    output logic [2:0]                stat_last_err,
    output logic                      err_pulse
);

    localparam int KW = DATA_WIDTH / 8;
    localparam int LB = $clog2(KW);
    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int AW = PW - 1;
    localparam int CW = $clog2(MAX_PKT_BEATS + 1);
    localparam int MW = DATA_WIDTH + KW + 1;

    localparam logic [2:0] E_NONE  = 3'd0;
    localparam logic [2:0] E_MAGIC = 3'd1;
    localparam logic [2:0] E_LEN   = 3'd2;
    localparam logic [2:0] E_EARLY = 3'd3;
    localparam logic [2:0] E_MISS  = 3'd4;
    localparam logic [2:0] E_KEEP  = 3'd5;

    typedef enum logic [1:0] {
        S_HDR,
        S_BODY,
        S_DROP
    } state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
    logic [CW-1:0]   exp_beats_q, exp_beats_d;
    logic [KW-1:0]   last_keep_q, last_keep_d;
    logic [31:0]     stat_good_q, stat_drop_q;
    logic [2:0]      last_err_q;
    logic            err_pulse_q;

    logic [MW-1:0]   mem_q [FIFO_DEPTH];

    logic            full;
    logic            accept;
    logic            mem_we;
    logic            wr_en;
    logic            commit;
    logic [2:0]      err_code;
    logic [15:0]     hdr_len;
    logic [16:0]     hdr_beats;
    logic [LB-1:0]   hdr_rem;
    logic [KW-1:0]   hdr_keep;
    logic            body_last_idx;
    logic [MW-1:0]   rd_word;

    // Occupancy counts everything written, committed or not, so an in-flight
    // packet can never overrun unread committed data.
    assign full          = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
    assign s_axis_tready = (state_q == S_DROP) || !full;
    assign accept        = s_axis_tvalid && s_axis_tready;

    assign hdr_len   = s_axis_tdata[31:16];
    assign hdr_beats = ({1'b0, hdr_len} + 17'(KW - 1)) >> LB;
    assign hdr_rem   = hdr_len[LB-1:0];

    // Final-beat byte mask: low (len mod KW) bytes, or a full beat when the
    // length is an exact multiple of the beat size.
    always_comb begin
        hdr_keep = '0;
        for (int i = 0; i < KW; i++) begin
            hdr_keep[i] = (hdr_rem == '0) || (i < int'(hdr_rem));
        end
    end

    assign body_last_idx = (beat_cnt_q == exp_beats_q - CW'(1));

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        beat_cnt_d   = beat_cnt_q;
        exp_beats_d  = exp_beats_q;
        last_keep_d  = last_keep_q;
        wr_en        = 1'b0;
        commit       = 1'b0;
        err_code     = E_NONE;

        if (accept) begin
            unique case (state_q)
                S_HDR: begin
                    if (s_axis_tdata[15:0] != MAGIC) begin
                        err_code = E_MAGIC;
                    end else if (hdr_len < 16'd8 ||
                                 hdr_beats > 17'(MAX_PKT_BEATS)) begin
                        err_code = E_LEN;
                    end else begin
                        wr_en       = 1'b1;
                        beat_cnt_d  = CW'(1);
                        exp_beats_d = CW'(hdr_beats);
                        last_keep_d = hdr_keep;
                        if (s_axis_tlast) begin
                            if (hdr_beats != 17'd1)          err_code = E_EARLY;
                            else if (s_axis_tkeep != hdr_keep) err_code = E_KEEP;
                            else                             commit   = 1'b1;
                        end else begin
                            // A header that is not the final beat is an
                            // ordinary body beat as far as tkeep goes.
                            if (s_axis_tkeep != {KW{1'b1}})  err_code = E_KEEP;
                            else if (hdr_beats == 17'd1)     err_code = E_MISS;
                            else                             state_d  = S_BODY;
                        end
                    end
                end
                S_BODY: begin
                    wr_en      = 1'b1;
                    beat_cnt_d = beat_cnt_q + CW'(1);
                    if (s_axis_tlast) begin
                        if (!body_last_idx)                     err_code = E_EARLY;
                        else if (s_axis_tkeep != last_keep_q)   err_code = E_KEEP;
                        else                                    commit   = 1'b1;
                    end else begin
                        if (s_axis_tkeep != {KW{1'b1}})         err_code = E_KEEP;
                        else if (body_last_idx)                 err_code = E_MISS;
                    end
                end
                S_DROP: begin
                    if (s_axis_tlast) state_d = S_HDR;
                end
                default: state_d = S_HDR;
            endcase
        end

        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);

        if (commit) begin
            commit_ptr_d = wr_ptr_q + PW'(1);
            state_d      = S_HDR;
        end

        // Rewinding to commit_ptr is always safe: rd_ptr never passes it.
        if (err_code != E_NONE) begin
            wr_ptr_d = commit_ptr_q;
            state_d  = s_axis_tlast ? S_HDR : S_DROP;
        end
    end

    assign mem_we = wr_en && (err_code == E_NONE);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        end
    end

    // First-word-fall-through egress: the head entry is committed and is not
    // rewritten while it is unread, so data holds steady under backpressure.
    assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];
    assign m_axis_tvalid = (rd_ptr_q != commit_ptr_q);
    assign m_axis_tdata  = rd_word[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = rd_word[DATA_WIDTH +: KW];
    assign m_axis_tlast  = rd_word[MW-1];
    assign rd_ptr_d      = (m_axis_tvalid && m_axis_tready) ? rd_ptr_q + PW'(1) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q      <= S_HDR;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            beat_cnt_q   <= '0;
            exp_beats_q  <= '0;
            last_keep_q  <= '0;
            stat_good_q  <= '0;
            stat_drop_q  <= '0;
            last_err_q   <= E_NONE;
            err_pulse_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            beat_cnt_q   <= beat_cnt_d;
            exp_beats_q  <= exp_beats_d;
            last_keep_q  <= last_keep_d;
            err_pulse_q  <= (err_code != E_NONE);
            if (commit && stat_good_q != 32'hFFFF_FFFF) begin
                stat_good_q <= stat_good_q + 32'd1;
            end
            if (err_code != E_NONE) begin
                last_err_q <= err_code;
                if (stat_drop_q != 32'hFFFF_FFFF) begin
                    stat_drop_q <= stat_drop_q + 32'd1;
                end
            end
        end
    end

    assign stat_good_pkts = stat_good_q;
    assign stat_drop_pkts = stat_drop_q;
    assign stat_last_err  = last_err_q;
    assign err_pulse      = err_pulse_q;

endmodule

// File: tb/tb_pcie_h2c_pkt_validator.sv
// Scoreboarded testbench for pcie_h2c_pkt_validator. Stimulus pushes expected
// output beats and expected drop codes into queues; a negedge monitor pops and
// compares whenever the DUT transfers a beat or pulses err_pulse.
module tb_pcie_h2c_pkt_validator;

    localparam int DW = 256;
    localparam int KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic          clk = 1'b0;
    logic          sys_rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tlast;
    logic          s_tvalid;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [31:0]   stat_good;
    logic [31:0]   stat_drop;
    logic [2:0]    stat_err;
    logic          err_pulse;

    beat_t exp_q[$];
    int    err_q[$];
    int    checks = 0;
    int    errors = 0;
    int    exp_good = 0;
    int    exp_drop = 0;
    beat_t mon_e;
    int    mon_code;

    always #2 clk = ~clk;

    pcie_h2c_pkt_validator dut (
        .clk            (clk),
        .sys_rst        (sys_rst),
        .s_axis_tdata   (s_tdata),
        .s_axis_tkeep   (s_tkeep),
        .s_axis_tlast   (s_tlast),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .m_axis_tdata   (m_tdata),
        .m_axis_tkeep   (m_tkeep),
        .m_axis_tlast   (m_tlast),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .stat_good_pkts (stat_good),
        .stat_drop_pkts (stat_drop),
        .stat_last_err  (stat_err),
        .err_pulse      (err_pulse)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: output beats and drop pulses.
    always @(negedge clk) begin
        if (!sys_rst && m_tvalid && m_tready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got beat %0h while none expected", m_tdata[63:0]);
            end else begin
                mon_e = exp_q.pop_front();
                if ({m_tdata, m_tkeep, m_tlast} !== mon_e) begin
                    errors++;
                    $display("FAIL out_beat: got d=%0h k=%0h l=%0b expected d=%0h k=%0h l=%0b",
                             m_tdata, m_tkeep, m_tlast, mon_e.d, mon_e.k, mon_e.l);
                end
            end
        end
        if (!sys_rst && err_pulse) begin
            checks++;
            if (err_q.size() == 0) begin
                errors++;
                $display("FAIL err_unexpected: got pulse code %0d while none expected", stat_err);
            end else begin
                mon_code = err_q.pop_front();
                if (int'(stat_err) != mon_code) begin
                    errors++;
                    $display("FAIL err_code: got %0d expected %0d", stat_err, mon_code);
                end
            end
        end
    end

    function automatic logic [DW-1:0] fill(input logic [7:0] tag, input int idx);
        return {8{tag, 8'(idx), 16'hBEAD}};
    endfunction

    function automatic logic [DW-1:0] hdr(input logic [7:0] tag, input logic [15:0] magic,
                                          input logic [15:0] len);
        logic [DW-1:0] d;
        d       = fill(tag, 0);
        d[63:0] = {24'h0, 8'h01, len, magic};
        return d;
    endfunction

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                             input bit chk_rdy);
        int w = 0;
        @(negedge clk);
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tvalid = 1'b1;
        if (chk_rdy) chk("drop_tready", 64'(s_tready), 64'd1);
        while (!s_tready && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (w >= 500) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got tready=0 for %0d cycles expected 1", w);
        end
        @(posedge clk);
    endtask

    // tlast is on beat nbeats-1; bad_idx (if >= 0) overrides that beat's tkeep.
    task automatic send_pkt(input logic [7:0] tag, input logic [15:0] magic,
                            input logic [15:0] len, input int nbeats,
                            input logic [KW-1:0] last_keep, input int bad_idx,
                            input logic [KW-1:0] bad_keep, input int err_code,
                            input int drop_from);
        beat_t b;
        if (err_code != 0) begin
            err_q.push_back(err_code);
            exp_drop++;
        end else begin
            exp_good++;
        end
        for (int i = 0; i < nbeats; i++) begin
            b.d = (i == 0) ? hdr(tag, magic, len) : fill(tag, i);
            b.k = (i == nbeats - 1) ? last_keep : {KW{1'b1}};
            if (i == bad_idx) b.k = bad_keep;
            b.l = (i == nbeats - 1);
            if (err_code == 0) exp_q.push_back(b);
            send_beat(b.d, b.k, b.l, (drop_from > 0) && (i >= drop_from));
        end
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (w >= 2000) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d beats %0d drops pending expected 0",
                     exp_q.size(), err_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_good"}, 64'(stat_good), 64'(exp_good));
        chk({tag, "_drop"}, 64'(stat_drop), 64'(exp_drop));
    endtask

    int gaps;

    initial begin
        sys_rst  = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sys_rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd1);
        chk("rst_err_pulse", 64'(err_pulse), 64'd0);
        chk("rst_last_err", 64'(stat_err), 64'd0);
        chk_stats("rst");

        // Good 3-beat packet, 80 bytes -> 16 bytes in last beat.
        send_pkt(8'h01, 16'hC0DE, 16'd80, 3, 32'h0000FFFF, -1, '0, 0, 0);
        drain();
        chk_stats("good3");

        // Bad magic, then a good single-beat packet.
        send_pkt(8'h02, 16'hBEEF, 16'd64, 2, {KW{1'b1}}, -1, '0, 1, 0);
        send_pkt(8'h03, 16'hC0DE, 16'd32, 1, {KW{1'b1}}, -1, '0, 0, 0);
        drain();
        chk_stats("magic");
        chk("magic_last_err", 64'(stat_err), 64'd1);

        // Early tlast: 4 beats declared, tlast on beat 2.
        send_pkt(8'h04, 16'hC0DE, 16'd128, 2, {KW{1'b1}}, -1, '0, 3, 0);
        drain();
        chk("early_last_err", 64'(stat_err), 64'd3);
        // Missing tlast: 2 beats declared, tlast on beat 5; beats 3-5 absorbed.
        send_pkt(8'h05, 16'hC0DE, 16'd64, 5, {KW{1'b1}}, -1, '0, 4, 2);
        drain();
        chk("miss_last_err", 64'(stat_err), 64'd4);
        // Bad tkeep on the final beat of a 64-byte packet.
        send_pkt(8'h06, 16'hC0DE, 16'd64, 2, {KW{1'b1}}, 1, 32'h7FFFFFFF, 5, 0);
        drain();
        chk("keep_last_err", 64'(stat_err), 64'd5);
        // Oversize: 1056 bytes = 33 beats.
        send_pkt(8'h07, 16'hC0DE, 16'd1056, 2, {KW{1'b1}}, -1, '0, 2, 0);
        drain();
        chk("over_last_err", 64'(stat_err), 64'd2);
        chk_stats("errs");

        // Backpressure: two full-size packets fill the 64-beat buffer.
        @(posedge clk);
        #1 m_tready = 1'b0;
        send_pkt(8'h10, 16'hC0DE, 16'd1024, 32, {KW{1'b1}}, -1, '0, 0, 0);
        send_pkt(8'h11, 16'hC0DE, 16'd1024, 32, {KW{1'b1}}, -1, '0, 0, 0);
        chk("bp_full_tready", 64'(s_tready), 64'd0);
        chk("bp_full_tvalid", 64'(m_tvalid), 64'd1);
        chk("bp_held", 64'(exp_q.size()), 64'd64);
        @(posedge clk);
        #1 m_tready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!m_tvalid) gaps++;
        end
        chk("bp_gaps", 64'(gaps), 64'd0);
        @(negedge clk);
        chk("bp_tready_back", 64'(s_tready), 64'd1);
        chk("bp_drained", 64'(exp_q.size()), 64'd0);
        drain();
        chk_stats("bp");

        // Reset after beat 2 of a 4-beat packet.
        send_beat(hdr(8'h20, 16'hC0DE, 16'd128), {KW{1'b1}}, 1'b0, 1'b0);
        send_beat(fill(8'h20, 1), {KW{1'b1}}, 1'b0, 1'b0);
        @(negedge clk);
        s_tvalid = 1'b0;
        sys_rst  = 1'b1;
        repeat (2) @(negedge clk);
        sys_rst  = 1'b0;
        exp_good = 0;
        exp_drop = 0;
        repeat (4) @(negedge clk);
        chk("rrst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rrst_last_err", 64'(stat_err), 64'd0);
        chk_stats("rrst");
        send_pkt(8'h21, 16'hC0DE, 16'd96, 3, {KW{1'b1}}, -1, '0, 0, 0);
        drain();
        chk_stats("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
